// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a one-entry skid buffer.
//
// Purpose:
//   Issues one instruction-memory read per cycle from the fetch PC (fpc) and
//   loads the IF/ID register with the returned word. The memory answers
//   exactly one cycle after a request. If that answer arrives while the
//   hazard unit stalls IF/ID, it is parked in a one-entry hold buffer and
//   replayed when the stall lifts, so no word is lost or fetched twice.
//   A redirect from EX flushes everything in flight and restarts at the
//   word-aligned target.
//
// Ports:
//   clk            in   1   clock, all state changes on the rising edge
//   reset          in   1   synchronous active-high reset
//   stall_i        in   1   hold IF/ID (hazard unit)
//   redirect_i     in   1   taken branch/jump from EX
//   redirect_pc_i  in  32   redirect target (low two bits ignored)
//   imem_req_o     out  1   instruction-memory read request
//   imem_addr_o    out 32   read address (always the fetch PC)
//   imem_rdata_i   in  32   read data, valid one cycle after the request
//   pc             out 32   IF/ID PC
//   instruction    out 32   IF/ID instruction
//   if_valid_o     out  1   IF/ID holds a real instruction
//   fetch_count_o  out 32   number of valid IF/ID loads (wraps)
//
// Memory handshake: a request is accepted on every rising edge where
// imem_req_o=1 (no backpressure from memory); the matching data is on
// imem_rdata_i during the following cycle and only then.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        if_valid_o,
    output logic [31:0] fetch_count_o
);

    logic [31:0] r_fpc;
    logic        r_resp_pending;
    logic [31:0] r_resp_pc;
    logic        r_hold_valid;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic [31:0] r_count;

    logic        w_req;
    logic [31:0] w_target;
    logic [1:0]  w_unused_bits;

    assign w_req         = !reset && !stall_i && !redirect_i;
    assign w_target      = {redirect_pc_i[31:2], 2'b00};
    assign w_unused_bits = redirect_pc_i[1:0];

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_fpc;
    assign pc            = r_pc;
    assign instruction   = r_instr;
    assign if_valid_o    = r_valid;
    assign fetch_count_o = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset wins over redirect and stall; a held word is dropped.
            r_fpc          <= RESET_PC;
            r_resp_pending <= 1'b0;
            r_resp_pc      <= 32'h0;
            r_hold_valid   <= 1'b0;
            r_hold_pc      <= 32'h0;
            r_hold_instr   <= NOP_INSTR;
            r_pc           <= 32'h0;
            r_instr        <= NOP_INSTR;
            r_valid        <= 1'b0;
            r_count        <= 32'h0;
        end else if (redirect_i) begin
            // Flush: the in-flight answer and any held word belong to the
            // wrong path. Redirect also overrides a simultaneous stall.
            r_fpc          <= w_target;
            r_resp_pending <= 1'b0;
            r_hold_valid   <= 1'b0;
            r_pc           <= 32'h0;
            r_instr        <= NOP_INSTR;
            r_valid        <= 1'b0;
        end else begin
            // Request side: only issued when neither stalled nor redirecting.
            if (w_req) begin
                r_fpc     <= r_fpc + 32'd4;
                r_resp_pc <= r_fpc;
            end
            r_resp_pending <= w_req;

            if (stall_i) begin
                // IF/ID holds. Requests stop while stalled, so at most one
                // answer (the one issued just before the stall) lands here.
                if (r_resp_pending) begin
                    r_hold_valid <= 1'b1;
                    r_hold_pc    <= r_resp_pc;
                    r_hold_instr <= imem_rdata_i;
                end
            end else if (r_hold_valid) begin
                // Drain the older, held word first; a word arriving now
                // takes its place in the buffer to keep program order.
                r_pc    <= r_hold_pc;
                r_instr <= r_hold_instr;
                r_valid <= 1'b1;
                r_count <= r_count + 32'd1;
                if (r_resp_pending) begin
                    r_hold_pc    <= r_resp_pc;
                    r_hold_instr <= imem_rdata_i;
                end else begin
                    r_hold_valid <= 1'b0;
                end
            end else begin
                r_pc    <= r_resp_pc;
                r_instr <= r_resp_pending ? imem_rdata_i : NOP_INSTR;
                r_valid <= r_resp_pending;
                if (r_resp_pending) begin
                    r_count <= r_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A directed table walks boot, stall/skid, redirect, redirect-under-stall,
// address wrap and reset-under-stall against hand-derived constants. A
// transaction-level model (a queue of fetched-but-undelivered PCs) runs
// alongside every cycle, directed and random, and predicts the IF/ID
// contents, the fetch count and the request address.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        if_valid_o;
    logic [31:0] fetch_count_o;

    int checks;
    int errors;

    if_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .pc           (pc),
        .instruction  (instruction),
        .if_valid_o   (if_valid_o),
        .fetch_count_o(fetch_count_o)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory: word n = 0x00100093 + n ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0010_0093 + (addr >> 2);
    endfunction

    initial imem_rdata_i = 32'h0;
    always @(posedge clk) begin
        if (imem_req_o) imem_rdata_i <= mem_word(imem_addr_o);
    end

    // ---------------- reference model ----------------
    logic [31:0] m_q[$];        // requested, not yet shown in IF/ID
    logic [31:0] m_next = RESET_PC;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic        m_pc_known = 1'b0;
    logic [31:0] m_instr = NOP_INSTR;
    logic [31:0] m_cnt = 32'h0;

    task automatic model_edge(input bit rs, input bit st, input bit rd,
                              input logic [31:0] tg);
        if (rs) begin
            m_q.delete();
            m_next = RESET_PC;
            m_valid = 1'b0; m_pc = 32'h0; m_pc_known = 1'b1;
            m_instr = NOP_INSTR; m_cnt = 32'h0;
        end else if (rd) begin
            m_q.delete();
            m_next = tg & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_pc = 32'h0; m_pc_known = 1'b1;
            m_instr = NOP_INSTR;
        end else if (!st) begin
            if (m_q.size() > 0) begin
                m_pc = m_q.pop_front();
                m_valid = 1'b1; m_pc_known = 1'b1;
                m_instr = mem_word(m_pc);
                m_cnt = m_cnt + 32'd1;
            end else begin
                m_valid = 1'b0; m_pc_known = 1'b0;
                m_instr = NOP_INSTR;
            end
            m_q.push_back(m_next);
            m_next = m_next + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs at the falling edge, check the request,
    // take the rising edge, then check IF/ID against the model.
    task automatic step(input bit rs, input bit st, input bit rd,
                        input logic [31:0] tg);
        bit exp_req;
        reset = rs; stall_i = st; redirect_i = rd; redirect_pc_i = tg;
        #1;
        exp_req = !rs && !st && !rd;
        chk("m_req", {31'h0, imem_req_o}, {31'h0, exp_req});
        if (exp_req) chk("m_addr", imem_addr_o, m_next);
        @(posedge clk);
        model_edge(rs, st, rd, tg);
        @(negedge clk);
        chk("m_valid", {31'h0, if_valid_o}, {31'h0, m_valid});
        chk("m_instr", instruction, m_instr);
        chk("m_count", fetch_count_o, m_cnt);
        if (m_pc_known) chk("m_pc", pc, m_pc);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rs;
        bit          st;
        bit          rd;
        logic [31:0] tg;
        bit          e_valid;
        bit          chk_pc;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tv[28];

    function automatic vec_t mk(input bit rs, input bit st, input bit rd,
                                input logic [31:0] tg, input bit ev,
                                input bit cp, input logic [31:0] ep,
                                input logic [31:0] ec);
        vec_t v;
        v.rs = rs; v.st = st; v.rd = rd; v.tg = tg;
        v.e_valid = ev; v.chk_pc = cp; v.e_pc = ep; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        logic [31:0] e_instr;
        checks = 0;
        errors = 0;
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

        //            rs st rd target         valid chkpc pc            count
        tv[0]  = mk(1, 0, 0, 32'h0,          0, 1, 32'h0,          0);  // boot reset
        tv[1]  = mk(1, 0, 0, 32'h0,          0, 1, 32'h0,          0);
        tv[2]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          0);  // first fetch in flight
        tv[3]  = mk(0, 0, 0, 32'h0,          1, 1, 32'h0,          1);
        tv[4]  = mk(0, 0, 0, 32'h0,          1, 1, 32'h4,          2);
        tv[5]  = mk(0, 1, 0, 32'h0,          1, 1, 32'h4,          2);  // stall, PC 8 in flight
        tv[6]  = mk(0, 1, 0, 32'h0,          1, 1, 32'h4,          2);
        tv[7]  = mk(0, 1, 0, 32'h0,          1, 1, 32'h4,          2);
        tv[8]  = mk(0, 0, 0, 32'h0,          1, 1, 32'h8,          3);  // replay from hold
        tv[9]  = mk(0, 0, 0, 32'h0,          1, 1, 32'hC,          4);
        tv[10] = mk(0, 0, 0, 32'h0,          1, 1, 32'h10,         5);
        tv[11] = mk(0, 0, 0, 32'h43,         0, 1, 32'h0,          5);  // redirect
        tv[12] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          5);
        tv[13] = mk(0, 0, 0, 32'h0,          1, 1, 32'h40,         6);
        tv[14] = mk(0, 0, 0, 32'h0,          1, 1, 32'h44,         7);
        tv[15] = mk(0, 1, 0, 32'h0,          1, 1, 32'h44,         7);  // hold fills
        tv[16] = mk(0, 1, 1, 32'h100,        0, 1, 32'h0,          7);  // redirect under stall
        tv[17] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          7);
        tv[18] = mk(0, 0, 0, 32'h0,          1, 1, 32'h100,        8);
        tv[19] = mk(0, 0, 1, 32'hFFFF_FFF8,  0, 1, 32'h0,          8);  // wrap
        tv[20] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          8);
        tv[21] = mk(0, 0, 0, 32'h0,          1, 1, 32'hFFFF_FFF8,  9);
        tv[22] = mk(0, 0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC, 10);
        tv[23] = mk(0, 0, 0, 32'h0,          1, 1, 32'h0,         11);
        tv[24] = mk(0, 1, 0, 32'h0,          1, 1, 32'h0,         11);  // hold fills
        tv[25] = mk(1, 1, 0, 32'h0,          0, 1, 32'h0,          0);  // reset mid-stall
        tv[26] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          0);
        tv[27] = mk(0, 0, 0, 32'h0,          1, 1, RESET_PC,       1);
        tv[11].rd = 1'b1;

        for (int i = 0; i < 28; i++) begin
            step(tv[i].rs, tv[i].st, tv[i].rd, tv[i].tg);
            e_instr = tv[i].e_valid ? mem_word(tv[i].e_pc) : NOP_INSTR;
            chk($sformatf("t%0d_valid", i), {31'h0, if_valid_o}, {31'h0, tv[i].e_valid});
            chk($sformatf("t%0d_instr", i), instruction, e_instr);
            chk($sformatf("t%0d_count", i), fetch_count_o, tv[i].e_cnt);
            if (tv[i].chk_pc) chk($sformatf("t%0d_pc", i), pc, tv[i].e_pc);
        end

        // ---------------- random phase against the model ----------------
        for (int n = 0; n < 800; n++) begin
            bit          rs, st, rd;
            logic [31:0] tg;
            rs = ($urandom_range(0, 63) == 0);
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                           tg = $urandom;
            step(rs, st, rd, tg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
